atm_cash_dispenser: RTL and testbench

- Responder side of the ATM dispense request. The ATM controller issues a one-cycle dispense request with a 15-bit amount; this block validates it and plans a greedy note breakdown (2000/500/100) against its live cassette inventory.
- On success it emits one note per cycle and pulses done; otherwise it pulses fail with a reason code.
- Sits between the ATM transaction controller and the mechanical note feeder.

---
 rtl/atm_cash_dispenser.sv | 167 ++++++++++++++++
 tb/tb_atm_cash_dispenser.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_cash_dispenser.sv
// Dispense responder: validates a request, plans a greedy 2000/500/100 breakdown
// against live cassette inventory, then feeds one note per cycle.
module atm_cash_dispenser #(
  parameter int N2000_INIT = 10,
  parameter int N500_INIT  = 20,
  parameter int N100_INIT  = 50,
  parameter int MAX_AMT    = 20000,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             disp_req,
  input  logic [14:0]      amt,
  input  logic             refill,
  output logic             busy,
  output logic             note_out,
  output logic [1:0]       note_type,
  output logic             done,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic [CNT_W-1:0] cnt2000,
  output logic [CNT_W-1:0] cnt500,
  output logic [CNT_W-1:0] cnt100
);

  typedef enum logic [2:0] {S_IDLE, S_PLAN, S_DISPENSE, S_DONE, S_FAIL} state_t;

  localparam logic [14:0]      MAX_AMT_W = 15'(MAX_AMT);
  localparam logic [14:0]      V2000     = 15'd2000;
  localparam logic [14:0]      V500      = 15'd500;
  localparam logic [14:0]      V100      = 15'd100;
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO      = '0;
  localparam logic [CNT_W-1:0] INIT2000  = CNT_W'(N2000_INIT);
  localparam logic [CNT_W-1:0] INIT500   = CNT_W'(N500_INIT);
  localparam logic [CNT_W-1:0] INIT100   = CNT_W'(N100_INIT);

  state_t           state_q, state_d;
  logic [14:0]      rem_q, rem_d;
  logic [CNT_W-1:0] p2000_q, p2000_d, p500_q, p500_d, p100_q, p100_d;
  logic [CNT_W-1:0] cnt2000_q, cnt2000_d, cnt500_q, cnt500_d, cnt100_q, cnt100_d;
  logic [1:0]       fail_code_q, fail_code_d;

  logic amt_valid, take2000, take500, take100, plan_stuck;
  logic sel2000, sel500, last_note;

  assign amt_valid  = (amt != 15'd0) && (amt <= MAX_AMT_W) && ((amt % V100) == 15'd0);
  assign take2000   = (rem_q >= V2000) && (p2000_q < cnt2000_q);
  assign take500    = (rem_q >= V500)  && (p500_q  < cnt500_q);
  assign take100    = (rem_q >= V100)  && (p100_q  < cnt100_q);
  assign plan_stuck = !take2000 && !take500 && !take100;

  // Notes leave in denomination order, so the largest non-empty plan count is the one being fed.
  assign sel2000   = (p2000_q != ZERO);
  assign sel500    = !sel2000 && (p500_q != ZERO);
  assign last_note = sel2000 ? (p2000_q == ONE && p500_q == ZERO && p100_q == ZERO)
                   : sel500  ? (p500_q == ONE && p100_q == ZERO)
                   :           (p100_q == ONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      p2000_q     <= '0;
      p500_q      <= '0;
      p100_q      <= '0;
      cnt2000_q   <= INIT2000;
      cnt500_q    <= INIT500;
      cnt100_q    <= INIT100;
      fail_code_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      p2000_q     <= p2000_d;
      p500_q      <= p500_d;
      p100_q      <= p100_d;
      cnt2000_q   <= cnt2000_d;
      cnt500_q    <= cnt500_d;
      cnt100_q    <= cnt100_d;
      fail_code_q <= fail_code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (disp_req) state_d = amt_valid ? S_PLAN : S_FAIL;
      S_PLAN:     if (plan_stuck) state_d = (rem_q == 15'd0) ? S_DISPENSE : S_FAIL;
      S_DISPENSE: if (last_note) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      S_FAIL:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rem_d       = rem_q;
    p2000_d     = p2000_q;
    p500_d      = p500_q;
    p100_d      = p100_q;
    cnt2000_d   = cnt2000_q;
    cnt500_d    = cnt500_q;
    cnt100_d    = cnt100_q;
    fail_code_d = fail_code_q;
    case (state_q)
      S_IDLE: begin
        if (disp_req) begin
          rem_d       = amt;
          p2000_d     = '0;
          p500_d      = '0;
          p100_d      = '0;
          fail_code_d = amt_valid ? 2'b00 : 2'b01;
        end else if (refill) begin
          cnt2000_d = INIT2000;
          cnt500_d  = INIT500;
          cnt100_d  = INIT100;
        end
      end
      S_PLAN: begin
        if (take2000) begin
          p2000_d = p2000_q + ONE;
          rem_d   = rem_q - V2000;
        end else if (take500) begin
          p500_d = p500_q + ONE;
          rem_d  = rem_q - V500;
        end else if (take100) begin
          p100_d = p100_q + ONE;
          rem_d  = rem_q - V100;
        end else if (rem_q != 15'd0) begin
          // Unfillable: drop the partial plan so nothing leaks into a later request.
          fail_code_d = 2'b10;
          rem_d       = '0;
          p2000_d     = '0;
          p500_d      = '0;
          p100_d      = '0;
        end
      end
      S_DISPENSE: begin
        if (sel2000) begin
          p2000_d   = p2000_q - ONE;
          cnt2000_d = cnt2000_q - ONE;
        end else if (sel500) begin
          p500_d   = p500_q - ONE;
          cnt500_d = cnt500_q - ONE;
        end else begin
          p100_d   = p100_q - ONE;
          cnt100_d = cnt100_q - ONE;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    note_out  = (state_q == S_DISPENSE);
    note_type = 2'b00;
    if (note_out) note_type = sel2000 ? 2'b11 : (sel500 ? 2'b10 : 2'b01);
    done      = (state_q == S_DONE);
    fail      = (state_q == S_FAIL);
    fail_code = fail_code_q;
    cnt2000   = cnt2000_q;
    cnt500    = cnt500_q;
    cnt100    = cnt100_q;
  end

endmodule

// File: tb/tb_atm_cash_dispenser.sv
// Scenario bench for atm_cash_dispenser: a greedy model fills an expected-note queue
// per request and each scenario pops it against the notes the DUT feeds.
module tb_atm_cash_dispenser;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        disp_req = 1'b0;
  logic [14:0] amt = '0;
  logic        refill = 1'b0;
  logic        busy, note_out, done, fail;
  logic [1:0]  note_type, fail_code;
  logic [7:0]  cnt2000, cnt500, cnt100;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m2000, m500, m100;
  logic [1:0] exp_q[$];
  logic [1:0] obs_q[$];
  int         obs_first, obs_done_cyc, obs_fail_cyc, obs_busy_notes;
  logic [1:0] obs_fcode;
  bit         obs_timeout;

  atm_cash_dispenser dut (
    .clk(clk), .rst(rst), .disp_req(disp_req), .amt(amt), .refill(refill),
    .busy(busy), .note_out(note_out), .note_type(note_type), .done(done),
    .fail(fail), .fail_code(fail_code),
    .cnt2000(cnt2000), .cnt500(cnt500), .cnt100(cnt100)
  );

  always #5 clk = ~clk;

  task automatic model_refill();
    m2000 = 8'd10; m500 = 8'd20; m100 = 8'd50;
  endtask

  // Greedy reference; fills exp_q and commits inventory only on success.
  task automatic predict(input logic [14:0] a, output bit valid, output bit ok, output int k);
    int r;
    logic [7:0] q2, q5, q1;
    exp_q.delete();
    valid = (a != 0) && (a <= 20000) && (a % 100 == 0);
    ok = 0; k = 0; r = a; q2 = 0; q5 = 0; q1 = 0;
    if (!valid) return;
    forever begin
      if (r >= 2000 && q2 < m2000) begin q2++; r -= 2000; end
      else if (r >= 500 && q5 < m500) begin q5++; r -= 500; end
      else if (r >= 100 && q1 < m100) begin q1++; r -= 100; end
      else break;
    end
    k = q2 + q5 + q1;
    ok = (r == 0);
    if (ok) begin
      repeat (q2) exp_q.push_back(2'b11);
      repeat (q5) exp_q.push_back(2'b10);
      repeat (q1) exp_q.push_back(2'b01);
      m2000 -= q2; m500 -= q5; m100 -= q1;
    end
  endtask

  // Issue one request and record what the DUT does, cycle-indexed from the capturing edge.
  task automatic applyStimulus(input logic [14:0] a, input bit with_refill, input int inject_at, input int max_cyc);
    bit finished = 0;
    obs_q.delete();
    obs_first = -1; obs_done_cyc = -1; obs_fail_cyc = -1; obs_fcode = 2'bxx; obs_timeout = 0;
    @(negedge clk);
    disp_req = 1'b1; amt = a; refill = with_refill;
    @(negedge clk);
    disp_req = 1'b0; refill = 1'b0;
    for (int i = 1; i <= max_cyc; i++) begin
      if (note_out) begin
        obs_q.push_back(note_type);
        if (obs_first < 0) obs_first = i;
      end
      if (done) begin obs_done_cyc = i; finished = 1; end
      if (fail) begin obs_fail_cyc = i; obs_fcode = fail_code; finished = 1; end
      if (i == inject_at) begin disp_req = 1'b1; amt = 15'd100; refill = 1'b1; end
      else begin disp_req = 1'b0; refill = 1'b0; end
      @(negedge clk);
      if (finished) break;
    end
    disp_req = 1'b0; refill = 1'b0;
    obs_timeout = !finished;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, note_out, note_type, done, fail, fail_code} !== 8'h00) begin
      n_bad++; $display("[TB] FAIL reset_outputs got=%b want=00000000", {busy, note_out, note_type, done, fail, fail_code});
    end
    n_cmp++;
    if ({cnt2000, cnt500, cnt100} !== {8'd10, 8'd20, 8'd50}) begin
      n_bad++; $display("[TB] FAIL reset_counts got=%0d/%0d/%0d want=10/20/50", cnt2000, cnt500, cnt100);
    end
    rst = 1'b1;
    model_refill();
    @(negedge clk);
  endtask

  task automatic test_basic_15000();
    bit v, ok; int k; logic [1:0] e, o;
    predict(15'd15000, v, ok, k);
    applyStimulus(15'd15000, 0, -1, 100);
    n_cmp++;
    if (obs_timeout || obs_fail_cyc >= 0) begin
      n_bad++; $display("[TB] FAIL basic_end timeout=%0d fail_cyc=%0d want done only", obs_timeout, obs_fail_cyc);
    end
    n_cmp++;
    if (obs_q.size() != 9 || exp_q.size() != 9) begin
      n_bad++; $display("[TB] FAIL basic_note_count got=%0d want=9", obs_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 2'bxx;
      n_cmp++;
      if (o !== e) begin n_bad++; $display("[TB] FAIL basic_note_type got=%b want=%b", o, e); end
    end
    n_cmp++;
    if (obs_first != k + 2 || obs_done_cyc != 2 * k + 2) begin
      n_bad++; $display("[TB] FAIL basic_latency first=%0d done=%0d want=%0d/%0d", obs_first, obs_done_cyc, k + 2, 2 * k + 2);
    end
    n_cmp++;
    if ({cnt2000, cnt500, cnt100} !== {8'd3, 8'd18, 8'd50}) begin
      n_bad++; $display("[TB] FAIL basic_counts got=%0d/%0d/%0d want=3/18/50", cnt2000, cnt500, cnt100);
    end
  endtask

  task automatic test_invalid();
    logic [14:0] bad_amts[3] = '{15'd20001, 15'd0, 15'd1550};
    bit v, ok; int k;
    foreach (bad_amts[j]) begin
      predict(bad_amts[j], v, ok, k);
      applyStimulus(bad_amts[j], 0, -1, 20);
      n_cmp++;
      if (v || obs_fail_cyc != 1 || obs_fcode !== 2'b01 || obs_q.size() != 0) begin
        n_bad++; $display("[TB] FAIL invalid_%0d fail_cyc=%0d code=%b notes=%0d want 1/01/0", bad_amts[j], obs_fail_cyc, obs_fcode, obs_q.size());
      end
      n_cmp++;
      if (fail !== 1'b0 || fail_code !== 2'b01 || {cnt2000, cnt500, cnt100} !== {m2000, m500, m100}) begin
        n_bad++; $display("[TB] FAIL invalid_hold fail=%b code=%b cnt=%0d/%0d/%0d", fail, fail_code, cnt2000, cnt500, cnt100);
      end
    end
  endtask

  task automatic test_insufficient();
    bit v, ok; int k;
    for (int it = 0; it < 5 && (m2000 != 0 || m500 != 0); it++) begin
      predict(15'd20000, v, ok, k);
      applyStimulus(15'd20000, 0, -1, 300);
      n_cmp++;
      if (ok ? (obs_done_cyc != 2 * k + 2 || obs_q.size() != k) : (obs_fail_cyc != k + 2)) begin
        n_bad++; $display("[TB] FAIL drain_%0d done=%0d fail=%0d notes=%0d k=%0d ok=%0d", it, obs_done_cyc, obs_fail_cyc, obs_q.size(), k, ok);
      end
    end
    n_cmp++;
    if ({cnt2000, cnt500, cnt100} !== {m2000, m500, m100}) begin
      n_bad++; $display("[TB] FAIL drain_counts got=%0d/%0d/%0d want=%0d/%0d/%0d", cnt2000, cnt500, cnt100, m2000, m500, m100);
    end
    predict(15'd20000, v, ok, k);
    applyStimulus(15'd20000, 0, -1, 300);
    n_cmp++;
    if (ok || obs_fail_cyc != k + 2 || obs_fcode !== 2'b10 || obs_q.size() != 0) begin
      n_bad++; $display("[TB] FAIL insufficient fail_cyc=%0d code=%b notes=%0d want %0d/10/0", obs_fail_cyc, obs_fcode, obs_q.size(), k + 2);
    end
    n_cmp++;
    if ({cnt2000, cnt500, cnt100} !== {m2000, m500, m100}) begin
      n_bad++; $display("[TB] FAIL insufficient_counts got=%0d/%0d/%0d want=%0d/%0d/%0d", cnt2000, cnt500, cnt100, m2000, m500, m100);
    end
  endtask

  task automatic test_refill();
    bit v, ok; int k; logic [1:0] e, o;
    @(negedge clk); refill = 1'b1;
    @(negedge clk); refill = 1'b0;
    model_refill();
    n_cmp++;
    if ({cnt2000, cnt500, cnt100} !== {8'd10, 8'd20, 8'd50}) begin
      n_bad++; $display("[TB] FAIL refill_counts got=%0d/%0d/%0d want=10/20/50", cnt2000, cnt500, cnt100);
    end
    predict(15'd100, v, ok, k);
    applyStimulus(15'd100, 0, -1, 20);
    n_cmp++;
    if (obs_done_cyc != 4 || obs_q.size() != 1) begin
      n_bad++; $display("[TB] FAIL refill_100 done=%0d notes=%0d want 4/1", obs_done_cyc, obs_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 2'bxx;
      n_cmp++;
      if (o !== e) begin n_bad++; $display("[TB] FAIL refill_note_type got=%b want=%b", o, e); end
    end
    n_cmp++;
    if (cnt100 !== 8'd49 || cnt100 !== m100) begin
      n_bad++; $display("[TB] FAIL refill_cnt100 got=%0d want=49", cnt100);
    end
  endtask

  task automatic test_busy_ignore();
    bit v, ok; int k; logic [1:0] e, o;
    predict(15'd6000, v, ok, k);
    // Refill alongside the request must lose; another request+refill lands mid-DISPENSE.
    applyStimulus(15'd6000, 1, k + 2, 50);
    n_cmp++;
    if (obs_q.size() != 3 || obs_done_cyc != 2 * k + 2) begin
      n_bad++; $display("[TB] FAIL busy_notes notes=%0d done=%0d want 3/%0d", obs_q.size(), obs_done_cyc, 2 * k + 2);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 2'bxx;
      n_cmp++;
      if (o !== e) begin n_bad++; $display("[TB] FAIL busy_note_type got=%b want=%b", o, e); end
    end
    obs_busy_notes = 0;
    repeat (6) begin
      if (busy || note_out || done) obs_busy_notes++;
      @(negedge clk);
    end
    n_cmp++;
    if (obs_busy_notes != 0) begin
      n_bad++; $display("[TB] FAIL busy_after_done active_cycles=%0d want=0", obs_busy_notes);
    end
    n_cmp++;
    if ({cnt2000, cnt500, cnt100} !== {m2000, m500, m100}) begin
      n_bad++; $display("[TB] FAIL busy_counts got=%0d/%0d/%0d want=%0d/%0d/%0d", cnt2000, cnt500, cnt100, m2000, m500, m100);
    end
  endtask

  task automatic test_partial_fail();
    bit v, ok; int k;
    @(negedge clk); refill = 1'b1;
    @(negedge clk); refill = 1'b0;
    model_refill();
    predict(15'd20000, v, ok, k);
    applyStimulus(15'd20000, 0, -1, 100);
    predict(15'd20000, v, ok, k);
    applyStimulus(15'd20000, 0, -1, 200);
    n_cmp++;
    if (ok || k != 70 || obs_fail_cyc != 72 || obs_fcode !== 2'b10 || obs_q.size() != 0) begin
      n_bad++; $display("[TB] FAIL partial_fail fail_cyc=%0d code=%b notes=%0d want 72/10/0", obs_fail_cyc, obs_fcode, obs_q.size());
    end
    n_cmp++;
    if ({cnt2000, cnt500, cnt100} !== {8'd0, 8'd20, 8'd50}) begin
      n_bad++; $display("[TB] FAIL partial_counts got=%0d/%0d/%0d want=0/20/50", cnt2000, cnt500, cnt100);
    end
  endtask

  task automatic test_reset_mid();
    bit v, ok, seen; int k; logic [1:0] e, o;
    @(negedge clk); refill = 1'b1;
    @(negedge clk); refill = 1'b0;
    model_refill();
    @(negedge clk); disp_req = 1'b1; amt = 15'd6000;
    @(negedge clk); disp_req = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (note_out) seen = 1; else @(negedge clk);
    end
    n_cmp++;
    if (!seen) begin n_bad++; $display("[TB] FAIL reset_mid_first_note got=none want=note within 20 cycles"); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, note_out, note_type, done, fail, fail_code} !== 8'h00 || {cnt2000, cnt500, cnt100} !== {8'd10, 8'd20, 8'd50}) begin
      n_bad++; $display("[TB] FAIL reset_mid_state outs=%b cnt=%0d/%0d/%0d want 0 and 10/20/50",
                        {busy, note_out, note_type, done, fail, fail_code}, cnt2000, cnt500, cnt100);
    end
    rst = 1'b1;
    obs_busy_notes = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || note_out || busy) obs_busy_notes++;
    end
    n_cmp++;
    if (obs_busy_notes != 0) begin n_bad++; $display("[TB] FAIL reset_mid_quiet active_cycles=%0d want=0", obs_busy_notes); end
    predict(15'd6000, v, ok, k);
    applyStimulus(15'd6000, 0, -1, 30);
    n_cmp++;
    if (obs_q.size() != 3 || obs_done_cyc != 8) begin
      n_bad++; $display("[TB] FAIL reset_mid_redo notes=%0d done=%0d want 3/8", obs_q.size(), obs_done_cyc);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 2'bxx;
      n_cmp++;
      if (o !== e) begin n_bad++; $display("[TB] FAIL reset_mid_note_type got=%b want=%b", o, e); end
    end
    n_cmp++;
    if ({cnt2000, cnt500, cnt100} !== {8'd7, 8'd20, 8'd50}) begin
      n_bad++; $display("[TB] FAIL reset_mid_counts got=%0d/%0d/%0d want=7/20/50", cnt2000, cnt500, cnt100);
    end
  endtask

  initial begin
    test_reset();
    test_basic_15000();
    test_invalid();
    test_insufficient();
    test_refill();
    test_busy_ignore();
    test_partial_fail();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
